// File: rtl/vjtag_bus_pkg.sv
// Shared types and defaults for the JTAG-host bus arbiter.
package vjtag_bus_pkg;

    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StGrant    = 2'd1,
        StWaitResp = 2'd2
    } arb_state_e;

    localparam int unsigned DEFAULT_AW = 16;
    localparam int unsigned DEFAULT_DW = 16;
    localparam logic [15:0] DEFAULT_ERR_DATA = 16'hDEAD;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester strictly after the last-grant pointer.
module rr_arbiter #(
    parameter int unsigned NM = 2
) (
    input  logic [NM-1:0]         req_i,
    input  logic [$clog2(NM)-1:0] ptr_i,
    output logic [NM-1:0]         gnt_o
);

    localparam int unsigned IW = $clog2(NM);

    logic          found;
    logic [IW-1:0] idx;

    always_comb begin
        gnt_o = '0;
        found = 1'b0;
        idx   = '0;
        // Offset NM wraps back onto the pointer itself, so a lone last-winner still gets served.
        for (int unsigned off = 1; off <= NM; off++) begin
            idx = IW'((32'(ptr_i) + off) % NM);
            if (!found && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/vjtag_bus_arbiter.sv
// Round-robin arbiter sharing one JTAG-host style slave port between NM masters,
// holding grant through the read response and bounding the wait with a timeout.
module vjtag_bus_arbiter
    import vjtag_bus_pkg::*;
#(
    parameter int unsigned    NM       = 2,
    parameter int unsigned    AW       = DEFAULT_AW,
    parameter int unsigned    DW       = DEFAULT_DW,
    parameter int unsigned    TIMEOUT  = 255,
    parameter logic [DW-1:0]  ERR_DATA = DW'(DEFAULT_ERR_DATA)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NM*AW-1:0] m_address,
    input  logic [NM-1:0]    m_wvalid,
    input  logic [NM*DW-1:0] m_wdata,
    output logic [NM-1:0]    m_wready,
    input  logic [NM-1:0]    m_rvalid,
    output logic [NM-1:0]    m_rready,
    output logic [NM-1:0]    m_rrvalid,
    output logic [DW-1:0]    m_rdata,
    output logic [AW-1:0]    s_address,
    output logic             s_wvalid,
    output logic [DW-1:0]    s_wdata,
    input  logic             s_wready,
    output logic             s_rvalid,
    input  logic             s_rready,
    input  logic             s_rrvalid,
    input  logic [DW-1:0]    s_rdata,
    output logic [NM-1:0]    grant,
    output logic             timeout_err
);

    localparam int unsigned IW = $clog2(NM);
    localparam int unsigned CW = $clog2(TIMEOUT);

    arb_state_e    state_q, state_d;
    logic [NM-1:0] grant_q, grant_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic [NM-1:0] req;
    logic [NM-1:0] arb_gnt;
    logic [IW-1:0] gidx;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;
    logic          sel_wv;
    logic          sel_rv;

    assign req   = m_wvalid | m_rvalid;
    assign grant = grant_q;

    rr_arbiter #(
        .NM(NM)
    ) u_rr_arbiter (
        .req_i(req),
        .ptr_i(ptr_q),
        .gnt_o(arb_gnt)
    );

    always_comb begin
        gidx = '0;
        for (int i = 0; i < int'(NM); i++) begin
            if (grant_q[i]) begin
                gidx = IW'(i);
            end
        end
    end

    assign sel_addr  = m_address[gidx*AW +: AW];
    assign sel_wdata = m_wdata[gidx*DW +: DW];
    assign sel_wv    = m_wvalid[gidx];
    assign sel_rv    = m_rvalid[gidx];

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        s_address   = '0;
        s_wdata     = '0;
        s_wvalid    = 1'b0;
        s_rvalid    = 1'b0;
        m_wready    = '0;
        m_rready    = '0;
        m_rrvalid   = '0;
        m_rdata     = '0;
        timeout_err = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (|req) begin
                    grant_d = arb_gnt;
                    state_d = StGrant;
                end
            end

            StGrant: begin
                s_address = sel_addr;
                s_wdata   = sel_wdata;
                s_wvalid  = sel_wv;
                // A combined write+read request is split: write now, read in a later grant.
                s_rvalid  = sel_rv & ~sel_wv;
                m_wready[gidx] = s_wready & sel_wv;
                m_rready[gidx] = s_rready & sel_rv & ~sel_wv;
                if (sel_wv && s_wready) begin
                    ptr_d   = gidx;
                    grant_d = '0;
                    state_d = StIdle;
                end else if (sel_rv && !sel_wv && s_rready) begin
                    cnt_d   = '0;
                    state_d = StWaitResp;
                end else if (!sel_wv && !sel_rv) begin
                    // Master abandoned its request; release without rotating priority.
                    grant_d = '0;
                    state_d = StIdle;
                end
            end

            StWaitResp: begin
                if (s_rrvalid) begin
                    m_rrvalid[gidx] = 1'b1;
                    m_rdata         = s_rdata;
                    ptr_d           = gidx;
                    grant_d         = '0;
                    state_d         = StIdle;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    m_rrvalid[gidx] = 1'b1;
                    m_rdata         = ERR_DATA;
                    timeout_err     = 1'b1;
                    ptr_d           = gidx;
                    grant_d         = '0;
                    state_d         = StIdle;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            default: begin
                grant_d = '0;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            grant_q <= '0;
            ptr_q   <= IW'(NM - 1);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_vjtag_bus_arbiter.sv
// Directed bench for vjtag_bus_arbiter with two masters and a short response timeout.
module tb_vjtag_bus_arbiter;

    localparam int unsigned NM = 2;
    localparam int unsigned AW = 16;
    localparam int unsigned DW = 16;
    localparam int unsigned TO = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic [NM*AW-1:0] m_address;
    logic [NM-1:0]    m_wvalid;
    logic [NM*DW-1:0] m_wdata;
    logic [NM-1:0]    m_wready;
    logic [NM-1:0]    m_rvalid;
    logic [NM-1:0]    m_rready;
    logic [NM-1:0]    m_rrvalid;
    logic [DW-1:0]    m_rdata;
    logic [AW-1:0]    s_address;
    logic             s_wvalid;
    logic [DW-1:0]    s_wdata;
    logic             s_wready;
    logic             s_rvalid;
    logic             s_rready;
    logic             s_rrvalid;
    logic [DW-1:0]    s_rdata;
    logic [NM-1:0]    grant;
    logic             timeout_err;

    int total = 0;
    int bad   = 0;

    vjtag_bus_arbiter #(
        .NM(NM),
        .AW(AW),
        .DW(DW),
        .TIMEOUT(TO),
        .ERR_DATA(16'hDEAD)
    ) dut (
        .clk(clk),
        .rst(rst),
        .m_address(m_address),
        .m_wvalid(m_wvalid),
        .m_wdata(m_wdata),
        .m_wready(m_wready),
        .m_rvalid(m_rvalid),
        .m_rready(m_rready),
        .m_rrvalid(m_rrvalid),
        .m_rdata(m_rdata),
        .s_address(s_address),
        .s_wvalid(s_wvalid),
        .s_wdata(s_wdata),
        .s_wready(s_wready),
        .s_rvalid(s_rvalid),
        .s_rready(s_rready),
        .s_rrvalid(s_rrvalid),
        .s_rdata(s_rdata),
        .grant(grant),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; m_address = '0; m_wvalid = '0; m_wdata = '0; m_rvalid = '0;
        s_wready = 1'b0; s_rready = 1'b0; s_rrvalid = 1'b0; s_rdata = '0;
        tick(); tick();
        total++; if (grant !== 2'b00) begin bad++; $display("FAIL rst_grant: got %b want 00", grant); end
        total++; if ({m_wready, m_rready, m_rrvalid} !== 6'b0) begin
            bad++; $display("FAIL rst_mready: got %b want 000000", {m_wready, m_rready, m_rrvalid});
        end
        total++; if ({s_wvalid, s_rvalid, timeout_err} !== 3'b000) begin
            bad++; $display("FAIL rst_svalid: got %b want 000", {s_wvalid, s_rvalid, timeout_err});
        end
        total++; if ({s_address, s_wdata, m_rdata} !== 48'h0) begin
            bad++; $display("FAIL rst_data: got %h want 0", {s_address, s_wdata, m_rdata});
        end
        rst = 1'b0;
    endtask

    task automatic test_single_write();
        m_wvalid = 2'b01; m_address[15:0] = 16'd4; m_wdata[15:0] = 16'h1234; s_wready = 1'b1;
        #1;
        total++; if (s_wvalid !== 1'b0) begin bad++; $display("FAIL wr_c0_swvalid: got %b want 0", s_wvalid); end
        tick();
        total++; if (s_wvalid !== 1'b1) begin bad++; $display("FAIL wr_c1_swvalid: got %b want 1", s_wvalid); end
        total++; if (s_address !== 16'd4) begin bad++; $display("FAIL wr_addr: got %h want 0004", s_address); end
        total++; if (s_wdata !== 16'h1234) begin bad++; $display("FAIL wr_data: got %h want 1234", s_wdata); end
        total++; if (m_wready !== 2'b01) begin bad++; $display("FAIL wr_mwready: got %b want 01", m_wready); end
        total++; if (grant !== 2'b01) begin bad++; $display("FAIL wr_grant: got %b want 01", grant); end
        tick();
        m_wvalid = 2'b00;
        #1;
        total++; if (grant !== 2'b00) begin bad++; $display("FAIL wr_c2_grant: got %b want 00", grant); end
    endtask

    task automatic test_read();
        // Master 0 also requests a write; the pointer sits on 0 so master 1 wins first.
        m_rvalid = 2'b10; m_address[31:16] = 16'd8;
        m_wvalid = 2'b01; m_wdata[15:0] = 16'h1111; s_wready = 1'b1; s_rready = 1'b1;
        tick();
        total++; if (grant !== 2'b10) begin bad++; $display("FAIL rd_grant: got %b want 10", grant); end
        total++; if ({s_rvalid, s_wvalid} !== 2'b10) begin
            bad++; $display("FAIL rd_svalid: got %b want 10", {s_rvalid, s_wvalid});
        end
        total++; if (s_address !== 16'd8) begin bad++; $display("FAIL rd_addr: got %h want 0008", s_address); end
        total++; if ({m_rready, m_wready} !== 4'b1000) begin
            bad++; $display("FAIL rd_ready: got %b want 1000", {m_rready, m_wready});
        end
        tick();
        m_rvalid = 2'b00;
        #1;
        for (int k = 0; k < 2; k++) begin
            if (k != 0) tick();
            total++; if ({m_rrvalid, m_wready, s_rvalid} !== 5'b0) begin
                bad++; $display("FAIL rd_wait%0d: got %b want 00000", k, {m_rrvalid, m_wready, s_rvalid});
            end
        end
        tick();
        s_rrvalid = 1'b1; s_rdata = 16'hA5A5;
        #1;
        total++; if (m_rrvalid !== 2'b10) begin bad++; $display("FAIL rd_rrvalid: got %b want 10", m_rrvalid); end
        total++; if (m_rdata !== 16'hA5A5) begin bad++; $display("FAIL rd_rdata: got %h want a5a5", m_rdata); end
        total++; if (m_wready !== 2'b00) begin bad++; $display("FAIL rd_m0_ready: got %b want 00", m_wready); end
        tick();
        s_rrvalid = 1'b0;
        #1;
        total++; if ({m_rrvalid, m_rdata} !== 18'h0) begin
            bad++; $display("FAIL rd_after: got %h want 0", {m_rrvalid, m_rdata});
        end
        tick();
        total++; if (m_wready !== 2'b01) begin bad++; $display("FAIL rd_m0_next: got %b want 01", m_wready); end
        tick();
        m_wvalid = 2'b00;
    endtask

    task automatic test_back_to_back();
        int n0 = 0;
        int n1 = 0;
        logic [1:0]  exp_g;
        logic [15:0] exp_d;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m_wvalid = 2'b11; m_wdata = {16'hBBBB, 16'hAAAA}; s_wready = 1'b1; s_rready = 1'b0;
        for (int t = 0; t < 8; t++) begin
            tick();
            exp_g = (t % 2 == 0) ? 2'b01 : 2'b10;
            exp_d = (t % 2 == 0) ? 16'hAAAA : 16'hBBBB;
            total++; if (grant !== exp_g) begin
                bad++; $display("FAIL b2b_grant%0d: got %b want %b", t, grant, exp_g);
            end
            total++; if (s_wdata !== exp_d) begin
                bad++; $display("FAIL b2b_data%0d: got %h want %h", t, s_wdata, exp_d);
            end
            if (m_wready == 2'b01) n0++;
            if (m_wready == 2'b10) n1++;
            tick();
        end
        m_wvalid = 2'b00;
        total++; if (n0 !== 4 || n1 !== 4) begin
            bad++; $display("FAIL b2b_counts: got %0d/%0d want 4/4", n0, n1);
        end
    endtask

    task automatic test_timeout();
        logic exp_t;
        m_rvalid = 2'b01; m_address[15:0] = 16'h0020; s_rready = 1'b1;
        tick();
        total++; if (m_rready !== 2'b01) begin bad++; $display("FAIL to_rready: got %b want 01", m_rready); end
        tick();
        m_rvalid = 2'b00;
        #1;
        for (int k = 0; k < int'(TO); k++) begin
            if (k != 0) tick();
            exp_t = (k == int'(TO) - 1);
            total++; if ({m_rrvalid[0], timeout_err} !== {exp_t, exp_t}) begin
                bad++; $display("FAIL to_cycle%0d: got %b want %b", k, {m_rrvalid[0], timeout_err}, {exp_t, exp_t});
            end
        end
        total++; if (m_rdata !== 16'hDEAD) begin bad++; $display("FAIL to_rdata: got %h want dead", m_rdata); end
        tick();
        tick();
        s_rrvalid = 1'b1; s_rdata = 16'hBEEF;
        #1;
        total++; if ({m_rrvalid, m_rdata, timeout_err} !== 19'h0) begin
            bad++; $display("FAIL to_late: got %h want 0", {m_rrvalid, m_rdata, timeout_err});
        end
        s_rrvalid = 1'b0;
    endtask

    task automatic test_reset_mid_read();
        m_rvalid = 2'b10; s_rready = 1'b1;
        tick();
        tick();
        m_rvalid = 2'b00; rst = 1'b1;
        #1;
        total++; if (grant !== 2'b10) begin bad++; $display("FAIL mr_held: got %b want 10", grant); end
        tick();
        rst = 1'b0; s_rrvalid = 1'b1; s_rdata = 16'h1111;
        #1;
        total++; if ({grant, m_rrvalid, m_rdata} !== 20'h0) begin
            bad++; $display("FAIL mr_cleared: got %h want 0", {grant, m_rrvalid, m_rdata});
        end
        s_rrvalid = 1'b0;
        m_wvalid = 2'b11; s_wready = 1'b1;
        tick();
        total++; if (grant !== 2'b01) begin bad++; $display("FAIL mr_first: got %b want 01", grant); end
        tick();
        m_wvalid = 2'b10;
        tick();
        total++; if (grant !== 2'b10) begin bad++; $display("FAIL mr_second: got %b want 10", grant); end
        tick();
        m_wvalid = 2'b00;
    endtask

    task automatic test_wr_then_rd();
        m_wvalid = 2'b01; m_rvalid = 2'b01; s_wready = 1'b1; s_rready = 1'b1;
        tick();
        total++; if ({s_wvalid, s_rvalid} !== 2'b10) begin
            bad++; $display("FAIL wr1_svalid: got %b want 10", {s_wvalid, s_rvalid});
        end
        total++; if ({m_wready, m_rready} !== 4'b0100) begin
            bad++; $display("FAIL wr1_ready: got %b want 0100", {m_wready, m_rready});
        end
        tick();
        m_wvalid = 2'b00;
        #1;
        total++; if ({grant, s_rvalid} !== 3'b000) begin
            bad++; $display("FAIL wr1_arb: got %b want 000", {grant, s_rvalid});
        end
        tick();
        total++; if ({s_wvalid, s_rvalid, m_rready} !== 4'b0101) begin
            bad++; $display("FAIL rd2_fwd: got %b want 0101", {s_wvalid, s_rvalid, m_rready});
        end
        tick();
        m_rvalid = 2'b00; s_rrvalid = 1'b1; s_rdata = 16'h5A5A;
        #1;
        total++; if ({m_rrvalid, m_rdata} !== {2'b01, 16'h5A5A}) begin
            bad++; $display("FAIL rd2_resp: got %h want 15a5a", {m_rrvalid, m_rdata});
        end
        tick();
        s_rrvalid = 1'b0;
    endtask

    task automatic test_drop();
        // Pointer is on master 0; an abandoned grant to master 1 must not rotate it.
        m_wvalid = 2'b10; s_wready = 1'b0;
        tick();
        total++; if (grant !== 2'b10) begin bad++; $display("FAIL drop_grant: got %b want 10", grant); end
        m_wvalid = 2'b00;
        tick();
        total++; if (grant !== 2'b00) begin bad++; $display("FAIL drop_release: got %b want 00", grant); end
        m_wvalid = 2'b11; s_wready = 1'b1;
        tick();
        total++; if (grant !== 2'b10) begin bad++; $display("FAIL drop_ptr: got %b want 10", grant); end
        tick();
        m_wvalid = 2'b00;
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_read();
        test_back_to_back();
        test_timeout();
        test_reset_mid_read();
        test_wr_then_rd();
        test_drop();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
